gen_scheduler: RTL and testbench

GEN_SCHEDULER -- requirements
Module: gen_scheduler

---
 rtl/gen_scheduler_if.sv | 28 ++
 rtl/gen_scheduler.sv | 158 +++++++++++++++
 tb/tb_gen_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_scheduler_if.sv
// Host grid-load handshake between a host loader (master) and the generation scheduler (slave).
interface gen_scheduler_if #(
    parameter int Y_SIZE = 720
);
    localparam int Y_WIDTH = $clog2(Y_SIZE);

    logic               init_start;
    logic               init_valid;
    logic               init_ready;
    logic               init_we;
    logic [Y_WIDTH-1:0] init_addr;

    modport master (
        output init_start,
        output init_valid,
        input  init_ready,
        input  init_we,
        input  init_addr
    );

    modport slave (
        input  init_start,
        input  init_valid,
        output init_ready,
        output init_we,
        output init_addr
    );
endinterface

// File: rtl/gen_scheduler.sv
// Generation scheduler: host grid load, row-by-row next-state calculation, and a tear-free bank swap at sof.
// Define GEN_SCHEDULER_GEN_COUNT_EN to add the 32-bit gen_count output.
module gen_scheduler #(
    parameter  int Y_SIZE  = 720,
    localparam int Y_WIDTH = $clog2(Y_SIZE)
) (
    input  logic               out_stream_aclk,
    input  logic               periph_reset,
    input  logic               step_req,
    input  logic               run,
    gen_scheduler_if.slave     init_bus,
    input  logic               row_valid,
    input  logic               sof,
    output logic               calc_flag,
    output logic [Y_WIDTH-1:0] calc_row,
    output logic               src_bank,
    output logic               busy,
    output logic               gen_done
`ifdef GEN_SCHEDULER_GEN_COUNT_EN
    ,
    output logic [31:0]        gen_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_SWAP_WAIT
    } state_t;

    localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [Y_WIDTH-1:0] ROW_ONE  = Y_WIDTH'(1);

    state_t             state_reg,     state_next;
    logic               pending_reg,   pending_next;
    logic               calc_flag_reg, calc_flag_next;
    logic [Y_WIDTH-1:0] calc_row_reg,  calc_row_next;
    logic [Y_WIDTH-1:0] init_addr_reg, init_addr_next;
    logic               src_bank_reg,  src_bank_next;
    logic               busy_reg,      busy_next;
    logic               gen_done_reg,  gen_done_next;
    logic               init_ready_c;
    logic               init_we_c;

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= 1'b0;
            calc_flag_reg <= 1'b0;
            calc_row_reg  <= '0;
            init_addr_reg <= '0;
            src_bank_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            gen_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            calc_flag_reg <= calc_flag_next;
            calc_row_reg  <= calc_row_next;
            init_addr_reg <= init_addr_next;
            src_bank_reg  <= src_bank_next;
            busy_reg      <= busy_next;
            gen_done_reg  <= gen_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        calc_flag_next = calc_flag_reg;
        calc_row_next  = calc_row_reg;
        init_addr_next = init_addr_reg;
        src_bank_next  = src_bank_reg;
        gen_done_next  = 1'b0;
        init_ready_c   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A host load takes precedence; a coincident step is remembered for afterwards.
                if (init_bus.init_start) begin
                    state_next     = ST_LOAD;
                    init_addr_next = '0;
                    pending_next   = pending_reg | step_req;
                end else if (step_req || pending_reg || run) begin
                    state_next     = ST_CALC;
                    calc_flag_next = 1'b1;
                    calc_row_next  = '0;
                    pending_next   = 1'b0;
                end
            end
            ST_LOAD: begin
                init_ready_c = 1'b1;
                if (init_bus.init_valid) begin
                    if (init_addr_reg == ROW_LAST) begin
                        state_next     = ST_IDLE;
                        init_addr_next = '0;
                    end else begin
                        init_addr_next = init_addr_reg + ROW_ONE;
                    end
                end
            end
            ST_CALC: begin
                if (row_valid) begin
                    if (calc_row_reg == ROW_LAST) begin
                        state_next     = ST_SWAP_WAIT;
                        calc_flag_next = 1'b0;
                        calc_row_next  = '0;
                    end else begin
                        calc_row_next = calc_row_reg + ROW_ONE;
                    end
                end
            end
            ST_SWAP_WAIT: begin
                // Swap only on a frame boundary so the display never shows a half-written bank.
                if (sof) begin
                    state_next    = ST_IDLE;
                    src_bank_next = ~src_bank_reg;
                    gen_done_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_reg != ST_IDLE && step_req) begin
            pending_next = 1'b1;
        end

        init_we_c = init_bus.init_valid & init_ready_c;
        busy_next = (state_next != ST_IDLE);
    end

`ifdef GEN_SCHEDULER_GEN_COUNT_EN
    logic [31:0] gen_count_reg;

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            gen_count_reg <= 32'd0;
        end else if (gen_done_next) begin
            gen_count_reg <= gen_count_reg + 32'd1;
        end
    end

    assign gen_count = gen_count_reg;
`endif

    assign init_bus.init_ready = init_ready_c;
    assign init_bus.init_we    = init_we_c;
    assign init_bus.init_addr  = init_addr_reg;
    assign calc_flag           = calc_flag_reg;
    assign calc_row            = calc_row_reg;
    assign src_bank            = src_bank_reg;
    assign busy                = busy_reg;
    assign gen_done            = gen_done_reg;

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler: drivers queue expected rows, load addresses and post-swap banks; a monitor checks them.
`timescale 1ns/1ps
module tb_gen_scheduler;
    localparam int Y_SIZE  = 720;
    localparam int Y_WIDTH = $clog2(Y_SIZE);

    logic               out_stream_aclk = 1'b0;
    logic               periph_reset    = 1'b1;
    logic               step_req        = 1'b0;
    logic               run             = 1'b0;
    logic               row_valid       = 1'b0;
    logic               sof             = 1'b0;
    logic               calc_flag;
    logic [Y_WIDTH-1:0] calc_row;
    logic               src_bank;
    logic               busy;
    logic               gen_done;
`ifdef GEN_SCHEDULER_GEN_COUNT_EN
    logic [31:0]        gen_count;
`endif

    gen_scheduler_if #(.Y_SIZE(Y_SIZE)) init_bus ();

    gen_scheduler #(.Y_SIZE(Y_SIZE)) dut (
        .out_stream_aclk (out_stream_aclk),
        .periph_reset    (periph_reset),
        .step_req        (step_req),
        .run             (run),
        .init_bus        (init_bus),
        .row_valid       (row_valid),
        .sof             (sof),
        .calc_flag       (calc_flag),
        .calc_row        (calc_row),
        .src_bank        (src_bank),
        .busy            (busy),
        .gen_done        (gen_done)
`ifdef GEN_SCHEDULER_GEN_COUNT_EN
        ,
        .gen_count       (gen_count)
`endif
    );

    always #5 out_stream_aclk = ~out_stream_aclk;

    int checks = 0;
    int errors = 0;
    int load_q[$];
    int row_q[$];
    int bank_q[$];
    int model_bank = 0;
    int model_gens = 0;
    logic prev_sof = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge out_stream_aclk);
        #1;
    endtask

    task automatic check_count();
`ifdef GEN_SCHEDULER_GEN_COUNT_EN
        check("gen_count", gen_count, model_gens);
`endif
    endtask

    // Monitor: compares DUT activity against whatever the drivers queued.
    always @(negedge out_stream_aclk) begin
        int exp;
        if (!periph_reset) begin
            if (init_bus.init_valid && load_q.size() > 0) begin
                exp = load_q.pop_front();
                check("init_we", init_bus.init_we, 1);
                check("init_addr", init_bus.init_addr, exp);
            end else if (init_bus.init_we) begin
                check("init_we_spurious", init_bus.init_we, 0);
            end
            if (row_valid && row_q.size() > 0) begin
                exp = row_q.pop_front();
                check("calc_flag_row", calc_flag, 1);
                check("calc_row", calc_row, exp);
            end
            if (gen_done) begin
                if (bank_q.size() == 0) begin
                    check("gen_done_unexpected", gen_done, 0);
                end else begin
                    exp = bank_q.pop_front();
                    check("gen_done_after_sof", prev_sof, 1);
                    check("src_bank_swap", src_bank, exp);
                end
            end
        end
        prev_sof = sof;
    end

    task automatic wait_calc();
        int n = 0;
        while (!calc_flag && n < 20) begin
            tick();
            n++;
        end
        check("calc_start", calc_flag, 1);
    endtask

    // One full generation: rows with random gaps and stray sof, then a swap at a later sof.
    task automatic run_gen(input bit sof_last, input int step_pulses, input bit expect_follow);
        int left = step_pulses;
        wait_calc();
        check("calc_row_start", calc_row, 0);
        for (int i = 0; i < Y_SIZE; i++) begin
            repeat ($urandom_range(0, 2)) begin
                sof = ($urandom_range(0, 7) == 0);
                tick();
            end
            sof = 1'b0;
            if (left > 0 && (i % 200) == 100) begin
                step_req = 1'b1;
                left--;
            end
            row_q.push_back(i);
            row_valid = 1'b1;
            if (i == Y_SIZE - 1) sof = sof_last;
            tick();
            row_valid = 1'b0;
            step_req  = 1'b0;
            sof       = 1'b0;
        end
        check("calc_flag_end", calc_flag, 0);
        check("busy_swap_wait", busy, 1);
        check("rows_consumed", row_q.size(), 0);
        model_bank ^= 1;
        model_gens++;
        bank_q.push_back(model_bank);
        repeat ($urandom_range(0, 4)) tick();
        check("no_early_swap", src_bank, model_bank ^ 1);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("calc_idle_at_done", calc_flag, 0);
        tick();
        check("gen_done_seen", bank_q.size(), 0);
        check("calc_follow", calc_flag, expect_follow);
        $display("gen %0d done src_bank=%0d follow=%0d", model_gens, src_bank, calc_flag);
    endtask

    task automatic do_load(input bit with_step);
        init_bus.init_start = 1'b1;
        step_req = with_step;
        tick();
        init_bus.init_start = 1'b0;
        step_req = 1'b0;
        check("load_busy", busy, 1);
        check("load_ready", init_bus.init_ready, 1);
        check("load_addr_start", init_bus.init_addr, 0);
        for (int i = 0; i < Y_SIZE; i++) begin
            repeat ($urandom_range(0, 2)) begin
                row_valid = ($urandom_range(0, 3) == 0);
                tick();
            end
            row_valid = 1'b0;
            load_q.push_back(i);
            init_bus.init_valid = 1'b1;
            tick();
            init_bus.init_valid = 1'b0;
        end
        check("load_done_busy", busy, 0);
        check("load_done_addr", init_bus.init_addr, 0);
        check("load_done_ready", init_bus.init_ready, 0);
        check("load_bank_kept", src_bank, model_bank);
        check("load_rows_consumed", load_q.size(), 0);
        $display("load done src_bank=%0d pending_step=%0d", src_bank, with_step);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_bus.init_start = 1'b0;
        init_bus.init_valid = 1'b0;
        repeat (3) tick();
        check("rst_calc_flag", calc_flag, 0);
        check("rst_calc_row", calc_row, 0);
        check("rst_init_addr", init_bus.init_addr, 0);
        check("rst_src_bank", src_bank, 0);
        check("rst_busy", busy, 0);
        check("rst_gen_done", gen_done, 0);
        check("rst_init_ready", init_bus.init_ready, 0);
        check("rst_init_we", init_bus.init_we, 0);
        check_count();
        periph_reset = 1'b0;

        // row_valid while idle must not start or advance anything
        repeat (3) begin row_valid = 1'b1; tick(); end
        row_valid = 1'b0;
        repeat (4) tick();
        check("idle_row_ignored", calc_row, 0);
        check("idle_row_busy", busy, 0);

        // single step, with an init_start during CALC that must be ignored
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("step_calc_flag", calc_flag, 1);
        check("step_calc_row", calc_row, 0);
        check("step_busy", busy, 1);
        init_bus.init_start = 1'b1;
        tick();
        init_bus.init_start = 1'b0;
        check("init_start_ignored", init_bus.init_ready, 0);
        run_gen(1'b0, 0, 1'b0);
        check_count();

        do_load(1'b0);

        // three requests during CALC collapse to one extra generation
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        run_gen(1'b1, 3, 1'b1);
        run_gen(1'b0, 0, 1'b0);
        repeat (5) tick();
        check("no_third_gen", busy, 0);
        check_count();

        // load and step together: load first, then calculation without a new request
        do_load(1'b1);
        tick();
        check("pending_after_load", calc_flag, 1);
        run_gen(1'b1, 0, 1'b0);
        check_count();

        // reset in the middle of CALC
        check("pre_reset_bank", src_bank, 0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        wait_calc();
        for (int i = 0; i < 300; i++) begin
            row_q.push_back(i);
            row_valid = 1'b1;
            tick();
        end
        row_valid = 1'b0;
        check("mid_calc_row", calc_row, 300);
        periph_reset = 1'b1;
        tick();
        periph_reset = 1'b0;
        check("calc_rst_flag", calc_flag, 0);
        check("calc_rst_row", calc_row, 0);
        check("calc_rst_bank", src_bank, 0);
        check("calc_rst_busy", busy, 0);
        model_bank = 0;
        model_gens = 0;
        repeat (3) tick();
        check("calc_rst_no_done", gen_done, 0);
        check_count();

        // free-running for three generations
        run = 1'b1;
        run_gen(($urandom_range(0, 1) == 1), 0, 1'b1);
        run_gen(($urandom_range(0, 1) == 1), 0, 1'b1);
        run = 1'b0;
        run_gen(($urandom_range(0, 1) == 1), 0, 1'b0);
        check("run_final_bank", src_bank, 1);
        check_count();

        // reset in the middle of LOAD
        init_bus.init_start = 1'b1;
        tick();
        init_bus.init_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            load_q.push_back(i);
            init_bus.init_valid = 1'b1;
            tick();
        end
        init_bus.init_valid = 1'b0;
        check("mid_load_addr", init_bus.init_addr, 100);
        periph_reset = 1'b1;
        tick();
        periph_reset = 1'b0;
        model_bank = 0;
        model_gens = 0;
        check("load_rst_busy", busy, 0);
        check("load_rst_addr", init_bus.init_addr, 0);
        check("load_rst_ready", init_bus.init_ready, 0);
        check("load_rst_bank", src_bank, 0);

        // randomized tail
        for (int g = 0; g < 2; g++) begin
            repeat ($urandom_range(1, 6)) tick();
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            run_gen(($urandom_range(0, 1) == 1), 0, 1'b0);
        end
        check("tail_bank", src_bank, 0);
        check_count();

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
